// File: rtl/pong_arena.sv
// Pong engine: command port, ball/paddle physics on FRAME_TICK, pixel colouring.
// result is combinational; VGA colour lags the pixel by one cycle; commands never stall.
module pong_arena #(
    parameter int         H_RES        = 640,
    parameter int         V_RES        = 480,
    parameter int         PAD_W        = 8,
    parameter int         PAD_H        = 60,
    parameter int         PAD1_X       = 20,
    parameter int         PAD2_X       = 620,
    parameter int         BALL_SZ      = 8,
    parameter int         BALL_SPD     = 2,
    parameter int         WIN_SCORE    = 7,
    parameter int         SERVE_FRAMES = 60,
    parameter logic [2:0] FG_RGB       = 3'b101,
    parameter logic [2:0] BG_RGB       = 3'b001
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        CLK_EN,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    input  logic        FRAME_TICK,
    input  logic        ACTIVE,
    input  logic [9:0]  PIX_X,
    input  logic [9:0]  PIX_Y,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [9:0]  PAD_MAX = 10'(V_RES - PAD_H);
    localparam logic [9:0]  PAD_RST = 10'((V_RES - PAD_H) / 2);
    localparam logic [9:0]  BALL_X0 = 10'(H_RES / 2 - BALL_SZ / 2);
    localparam logic [9:0]  BALL_Y0 = 10'(V_RES / 2 - BALL_SZ / 2);
    localparam logic [9:0]  HIT1_X  = 10'(PAD1_X + PAD_W);
    localparam logic [9:0]  HIT2_X  = 10'(PAD2_X - BALL_SZ);
    localparam logic [9:0]  X_MAX   = 10'(H_RES - BALL_SZ);
    localparam logic [9:0]  Y_MAX   = 10'(V_RES - BALL_SZ);
    localparam logic [7:0]  WIN     = 8'(WIN_SCORE);
    localparam logic [15:0] FC_LAST = 16'(SERVE_FRAMES - 1);

    // Signed 12-bit copies so x-SPD near the left wall cannot wrap.
    localparam logic signed [11:0] SPD_S   = 12'(BALL_SPD);
    localparam logic signed [11:0] HIT1_S  = 12'(PAD1_X + PAD_W);
    localparam logic signed [11:0] HIT1_LO = 12'(PAD1_X + PAD_W - BALL_SPD - 1);
    localparam logic signed [11:0] HIT2_S  = 12'(PAD2_X - BALL_SZ);
    localparam logic signed [11:0] HIT2_HI = 12'(PAD2_X - BALL_SZ + BALL_SPD + 1);
    localparam logic signed [11:0] XMAX_S  = 12'(H_RES - BALL_SZ);
    localparam logic signed [11:0] YMAX_S  = 12'(V_RES - BALL_SZ);

    state_t      state;
    logic [7:0]  score1, score2;
    logic [9:0]  pad1_y, pad2_y;
    logic [9:0]  ball_x, ball_y;
    logic        ball_dx, ball_dy;
    logic        serve_dir;
    logic [15:0] frame_cnt;
    logic [2:0]  vga_rgb;

    function automatic logic rows_overlap(input logic [9:0] top, input logic [9:0] py);
        return ({1'b0, top} <= {1'b0, py} + 11'(PAD_H - 1)) &&
               ({1'b0, top} + 11'(BALL_SZ - 1) >= {1'b0, py});
    endfunction

    function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] x0, input logic [9:0] y0,
                                    input logic [10:0] w, input logic [10:0] h);
        return ({1'b0, px} >= {1'b0, x0}) && ({1'b0, px} < {1'b0, x0} + w) &&
               ({1'b0, py} >= {1'b0, y0}) && ({1'b0, py} < {1'b0, y0} + h);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] s);
        return (s == 8'hFF) ? s : s + 8'd1;
    endfunction

    logic [2:0] cmd_op;
    logic [9:0] cmd_arg, cmd_y;
    logic       cmd_p1, cmd_p2, cmd_start, cmd_clear;
    logic       unused_dataa;

    assign cmd_op       = dataa[31:29];
    assign cmd_arg      = dataa[9:0];
    assign cmd_y        = (cmd_arg > PAD_MAX) ? PAD_MAX : cmd_arg;
    assign cmd_p1       = CLK_EN && (cmd_op == 3'd0);
    assign cmd_p2       = CLK_EN && (cmd_op == 3'd1);
    assign cmd_start    = CLK_EN && (cmd_op == 3'd2);
    assign cmd_clear    = CLK_EN && (cmd_op == 3'd3);
    assign unused_dataa = ^dataa[28:10];

    logic signed [11:0] x_s, y_s, nx_s, ny_s;
    logic [9:0]         y_next;
    logic               dy_next, hit1, hit2, miss_l, miss_r;

    always_comb begin
        x_s  = $signed({2'b00, ball_x});
        y_s  = $signed({2'b00, ball_y});
        nx_s = ball_dx ? x_s + SPD_S : x_s - SPD_S;
        ny_s = ball_dy ? y_s + SPD_S : y_s - SPD_S;
        y_next  = ny_s[9:0];
        dy_next = ball_dy;
        if (ny_s <= 12'sd0) begin
            y_next  = '0;
            dy_next = 1'b1;
        end else if (ny_s >= YMAX_S) begin
            y_next  = Y_MAX;
            dy_next = 1'b0;
        end
        // Paddle tests use the ball rows and paddle y as they stand before this tick.
        hit1   = !ball_dx && (nx_s <= HIT1_S) && (x_s > HIT1_LO) && rows_overlap(ball_y, pad1_y);
        hit2   = ball_dx && (nx_s >= HIT2_S) && (x_s < HIT2_HI) && rows_overlap(ball_y, pad2_y);
        miss_l = (nx_s <= 12'sd0);
        miss_r = (nx_s >= XMAX_S);
    end

    logic       ball_vis, on_pad, on_ball;
    logic [2:0] pix_rgb;

    always_comb begin
        ball_vis = (state == S_SERVE) || (state == S_PLAY) || (state == S_POINT);
        on_pad   = in_box(PIX_X, PIX_Y, 10'(PAD1_X), pad1_y, 11'(PAD_W), 11'(PAD_H)) ||
                   in_box(PIX_X, PIX_Y, 10'(PAD2_X), pad2_y, 11'(PAD_W), 11'(PAD_H));
        on_ball  = in_box(PIX_X, PIX_Y, ball_x, ball_y, 11'(BALL_SZ), 11'(BALL_SZ));
        pix_rgb  = 3'b000;
        if (ACTIVE)
            pix_rgb = (on_pad || (ball_vis && on_ball)) ? FG_RGB : BG_RGB;
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state     <= S_IDLE;
            score1    <= '0;
            score2    <= '0;
            pad1_y    <= PAD_RST;
            pad2_y    <= PAD_RST;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            ball_dx   <= 1'b1;
            ball_dy   <= 1'b1;
            serve_dir <= 1'b1;
            frame_cnt <= '0;
            vga_rgb   <= '0;
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    if (cmd_start) begin
                        state     <= S_SERVE;
                        score1    <= '0;
                        score2    <= '0;
                        serve_dir <= 1'b1;
                        ball_x    <= BALL_X0;
                        ball_y    <= BALL_Y0;
                        ball_dx   <= 1'b1;
                        ball_dy   <= 1'b1;
                        frame_cnt <= '0;
                    end
                end
                S_SERVE: begin
                    if (FRAME_TICK) begin
                        if (frame_cnt == FC_LAST) begin
                            frame_cnt <= '0;
                            state     <= S_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (FRAME_TICK) begin
                        ball_y  <= y_next;
                        ball_dy <= dy_next;
                        if (hit1) begin
                            ball_x  <= HIT1_X;
                            ball_dx <= 1'b1;
                        end else if (hit2) begin
                            ball_x  <= HIT2_X;
                            ball_dx <= 1'b0;
                        end else if (miss_l) begin
                            ball_x    <= '0;
                            score2    <= sat_inc(score2);
                            serve_dir <= 1'b0;
                            state     <= S_POINT;
                        end else if (miss_r) begin
                            ball_x    <= X_MAX;
                            score1    <= sat_inc(score1);
                            serve_dir <= 1'b1;
                            state     <= S_POINT;
                        end else begin
                            ball_x <= nx_s[9:0];
                        end
                    end
                end
                S_POINT: begin
                    if ((score1 == WIN) || (score2 == WIN)) begin
                        state <= S_OVER;
                    end else begin
                        state     <= S_SERVE;
                        ball_x    <= BALL_X0;
                        ball_y    <= BALL_Y0;
                        ball_dx   <= serve_dir;
                        ball_dy   <= 1'b1;
                        frame_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (cmd_clear) begin
                score1 <= '0;
                score2 <= '0;
            end
            if (cmd_p1) pad1_y <= cmd_y;
            if (cmd_p2) pad2_y <= cmd_y;
            vga_rgb <= pix_rgb;
        end
    end

    assign result = {13'd0, state, score2, score1};
    assign VGA_R  = vga_rgb[2];
    assign VGA_G  = vga_rgb[1];
    assign VGA_B  = vga_rgb[0];

endmodule

// File: tb/tb_pong_arena.sv
// Bench for pong_arena: fixed vector table, scripted game sequences, then random play vs a model.
module tb_pong_arena;

    localparam int H_RES = 640, V_RES = 480, PAD_W = 8, PAD_H = 60;
    localparam int PAD1_X = 20, PAD2_X = 620, BALL_SZ = 8, BALL_SPD = 2;
    localparam int WIN_SCORE = 7, SERVE_FRAMES = 60;
    localparam int PAD_LIM = V_RES - PAD_H;

    logic        CLK, RST_BTN, CLK_EN, FRAME_TICK, ACTIVE;
    logic [31:0] dataa, result;
    logic [9:0]  PIX_X, PIX_Y;
    logic        VGA_R, VGA_G, VGA_B;

    pong_arena dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .CLK_EN(CLK_EN), .dataa(dataa), .result(result),
        .FRAME_TICK(FRAME_TICK), .ACTIVE(ACTIVE), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference game state: plain integers, direction as +1/-1.
    int m_state, m_s1, m_s2, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_sdir, m_frames;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {29'd0, VGA_R, VGA_G, VGA_B};
    endfunction

    function automatic logic [31:0] cmd(input int op, input int arg);
        return {3'(op), 19'd0, 10'(arg)};
    endfunction

    function automatic int clamp_pad(input int v);
        if (v < 0) return 0;
        if (v > PAD_LIM) return PAD_LIM;
        return v;
    endfunction

    function automatic int track(input int by);
        return clamp_pad(by - 26);
    endfunction

    function automatic int away(input int by);
        return (by < 240) ? PAD_LIM : 0;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0;
        m_p1 = PAD_LIM / 2; m_p2 = PAD_LIM / 2;
        m_bx = H_RES / 2 - BALL_SZ / 2; m_by = V_RES / 2 - BALL_SZ / 2;
        m_vx = 1; m_vy = 1; m_sdir = 1; m_frames = 0;
    endfunction

    function automatic void model_serve();
        m_state = 1; m_frames = 0;
        m_bx = H_RES / 2 - BALL_SZ / 2; m_by = V_RES / 2 - BALL_SZ / 2;
        m_vx = m_sdir ? 1 : -1; m_vy = 1;
    endfunction

    function automatic void model_play(input int p1, input int p2);
        int nx, ny, ox, oy;
        bit ov1, ov2;
        ox = m_bx; oy = m_by;
        nx = ox + BALL_SPD * m_vx;
        ny = oy + BALL_SPD * m_vy;
        if (ny <= 0) begin m_by = 0; m_vy = 1; end
        else if (ny >= V_RES - BALL_SZ) begin m_by = V_RES - BALL_SZ; m_vy = -1; end
        else m_by = ny;
        ov1 = (oy <= p1 + PAD_H - 1) && (oy + BALL_SZ - 1 >= p1);
        ov2 = (oy <= p2 + PAD_H - 1) && (oy + BALL_SZ - 1 >= p2);
        if (m_vx < 0 && nx <= PAD1_X + PAD_W && ox > PAD1_X + PAD_W - BALL_SPD - 1 && ov1) begin
            m_bx = PAD1_X + PAD_W; m_vx = 1;
        end else if (m_vx > 0 && nx + BALL_SZ >= PAD2_X && ox + BALL_SZ < PAD2_X + BALL_SPD + 1 && ov2) begin
            m_bx = PAD2_X - BALL_SZ; m_vx = -1;
        end else if (nx <= 0) begin
            m_s2 = (m_s2 == 255) ? 255 : m_s2 + 1; m_sdir = 0; m_bx = 0; m_state = 3;
        end else if (nx >= H_RES - BALL_SZ) begin
            m_s1 = (m_s1 == 255) ? 255 : m_s1 + 1; m_sdir = 1; m_bx = H_RES - BALL_SZ; m_state = 3;
        end else begin
            m_bx = nx;
        end
    endfunction

    function automatic void model_step(input logic en, input logic [31:0] d, input logic tk);
        int op, arg, p1o, p2o;
        op = int'(d[31:29]); arg = int'(d[9:0]);
        p1o = m_p1; p2o = m_p2;
        case (m_state)
            0, 4: if (en && op == 2) begin m_s1 = 0; m_s2 = 0; m_sdir = 1; model_serve(); end
            1: if (tk) begin m_frames++; if (m_frames == SERVE_FRAMES) m_state = 2; end
            2: if (tk) model_play(p1o, p2o);
            3: if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) m_state = 4; else model_serve();
            default: ;
        endcase
        if (en && op == 3) begin m_s1 = 0; m_s2 = 0; end
        if (en && op == 0) m_p1 = clamp_pad(arg);
        if (en && op == 1) m_p2 = clamp_pad(arg);
    endfunction

    function automatic logic [31:0] model_result();
        return {13'd0, 3'(m_state), 8'(m_s2), 8'(m_s1)};
    endfunction

    function automatic logic [31:0] model_pix(input logic act, input int px, input int py);
        bit fg;
        if (!act) return 32'd0;
        fg = (px >= PAD1_X && px < PAD1_X + PAD_W && py >= m_p1 && py < m_p1 + PAD_H) ||
             (px >= PAD2_X && px < PAD2_X + PAD_W && py >= m_p2 && py < m_p2 + PAD_H) ||
             (m_state >= 1 && m_state <= 3 && px >= m_bx && px < m_bx + BALL_SZ &&
              py >= m_by && py < m_by + BALL_SZ);
        return fg ? 32'd5 : 32'd1;
    endfunction

    // One clock with model comparison: result before the edge, colour after it.
    task automatic run(input logic en, input logic [31:0] d, input logic tk, input logic act,
                       input int px, input int py);
        logic [31:0] e_pix;
        CLK_EN = en; dataa = d; FRAME_TICK = tk; ACTIVE = act;
        PIX_X = 10'(px); PIX_Y = 10'(py);
        #1;
        check("result", result, model_result());
        e_pix = model_pix(act, px, py);
        @(posedge CLK);
        model_step(en, d, tk);
        #1;
        check("rgb", rgb(), e_pix);
    endtask

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic        act;
        int          px;
        int          py;
        logic [31:0] exp_res;
        logic [2:0]  exp_rgb;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [19:0] pick_pix();
        int r, x, y;
        r = int'($urandom_range(0, 2));
        if (r == 0) begin
            x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
        end else if (r == 1) begin
            x = m_bx + int'($urandom_range(0, 11)) - 2; y = m_by + int'($urandom_range(0, 11)) - 2;
        end else begin
            x = ($urandom_range(0, 1) != 0 ? PAD1_X : PAD2_X) + int'($urandom_range(0, 11)) - 2;
            y = ($urandom_range(0, 1) != 0 ? m_p1 : m_p2) + int'($urandom_range(0, 63)) - 2;
        end
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        return {10'(x), 10'(y)};
    endfunction

    initial begin
        logic [19:0] pp;
        logic [31:0] d;
        logic        en, tk, act;
        int          r, yb;
        bit          found;

        tbl[0]  = '{1'b1, 32'h0000_0300, 1'b1, 22, 215, 32'h0, 3'b101};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 22, 215, 32'h0, 3'b001};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 22, 419, 32'h0, 3'b001};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 22, 420, 32'h0, 3'b101};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 22, 479, 32'h0, 3'b101};
        tbl[5]  = '{1'b1, 32'h2000_00F0, 1'b1, 625, 215, 32'h0, 3'b101};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 625, 239, 32'h0, 3'b001};
        tbl[7]  = '{1'b1, 32'h0000_00F0, 1'b1, 627, 299, 32'h0, 3'b101};
        tbl[8]  = '{1'b0, 32'h0,         1'b1, 628, 250, 32'h0, 3'b001};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 22, 250, 32'h0, 3'b101};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 22, 250, 32'h0, 3'b000};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 316, 236, 32'h0, 3'b001};
        tbl[12] = '{1'b1, 32'h8000_0000, 1'b1, 19, 250, 32'h0, 3'b001};
        tbl[13] = '{1'b1, 32'hE000_03FF, 1'b1, 20, 250, 32'h0, 3'b101};
        tbl[14] = '{1'b1, 32'h6000_0000, 1'b1, 22, 250, 32'h0, 3'b101};
        tbl[15] = '{1'b1, 32'h4000_0000, 1'b1, 316, 236, 32'h0, 3'b001};
        tbl[16] = '{1'b0, 32'h0,         1'b1, 316, 236, 32'h0001_0000, 3'b101};
        tbl[17] = '{1'b0, 32'h0,         1'b1, 315, 236, 32'h0001_0000, 3'b001};
        tbl[18] = '{1'b0, 32'h0,         1'b1, 323, 243, 32'h0001_0000, 3'b101};
        tbl[19] = '{1'b0, 32'h0,         1'b1, 324, 243, 32'h0001_0000, 3'b001};
        tbl[20] = '{1'b0, 32'h0,         1'b1, 323, 244, 32'h0001_0000, 3'b001};

        RST_BTN = 1'b1; CLK_EN = 1'b0; dataa = '0; FRAME_TICK = 1'b0;
        ACTIVE = 1'b0; PIX_X = '0; PIX_Y = '0;
        #2 RST_BTN = 1'b0;
        #1;
        model_reset();
        check("reset_result", result, 32'h0);
        check("reset_rgb", rgb(), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_BTN = 1'b1;

        foreach (tbl[i]) begin
            CLK_EN = tbl[i].en; dataa = tbl[i].d; FRAME_TICK = 1'b0; ACTIVE = tbl[i].act;
            PIX_X = 10'(tbl[i].px); PIX_Y = 10'(tbl[i].py);
            #1;
            check($sformatf("tbl%0d_result", i), result, tbl[i].exp_res);
            @(posedge CLK);
            model_step(tbl[i].en, tbl[i].d, 1'b0);
            #1;
            check($sformatf("tbl%0d_rgb", i), rgb(), {29'd0, tbl[i].exp_rgb});
        end

        // Serve countdown: still SERVE after 59 ticks, PLAY on the 60th.
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            run(1'b0, 32'h0, 1'b1, 1'b1, 316, 236);
            if (i == SERVE_FRAMES - 1) check("serve_59", {29'd0, result[18:16]}, 32'd1);
        end
        check("serve_60", {29'd0, result[18:16]}, 32'd2);
        run(1'b0, 32'h0, 1'b0, 1'b1, 316, 236);
        check("ball_at_316", rgb(), 32'd5);
        run(1'b0, 32'h0, 1'b1, 1'b1, 315, 236);
        check("ball_left_316", rgb(), 32'd1);
        run(1'b0, 32'h0, 1'b0, 1'b1, 317, 237);
        check("ball_moved_317", rgb(), 32'd1);
        run(1'b0, 32'h0, 1'b0, 1'b1, 318, 238);
        check("ball_at_318", rgb(), 32'd5);

        // Rally with both paddles tracking until the ball sits at x=30 heading left.
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (m_state == 2 && m_bx == 30 && m_vx < 0 &&
                m_by <= m_p1 + PAD_H - 1 && m_by + BALL_SZ - 1 >= m_p1) begin
                found = 1;
            end else begin
                pp = pick_pix();
                run(1'b1, cmd(i % 2, track(m_by)), 1'b1, 1'b1, int'(pp[19:10]), int'(pp[9:0]));
            end
        end
        if (!found) check("rally_timeout", 32'd1, 32'd0);
        run(1'b0, 32'h0, 1'b1, 1'b1, 0, 0);
        run(1'b0, 32'h0, 1'b1, 1'b1, 0, 0);
        check("hit_no_score", {16'd0, result[15:0]}, 32'd0);
        yb = m_by + 3;
        run(1'b0, 32'h0, 1'b0, 1'b1, 29, yb);
        check("hit_bounce_29", rgb(), 32'd1);
        run(1'b0, 32'h0, 1'b0, 1'b1, 37, yb);
        check("hit_bounce_37", rgb(), 32'd5);

        // Left miss: paddle1 kept clear of the ball.
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (m_state == 3) found = 1;
            else run(1'b1, (i % 2) ? cmd(1, track(m_by)) : cmd(0, away(m_by)), 1'b1, 1'b1, m_bx, m_by);
        end
        if (!found) check("miss_timeout", 32'd1, 32'd0);
        check("point_state", result, 32'h0003_0100);
        run(1'b0, 32'h0, 1'b1, 1'b1, 0, 0);
        check("point_one_cycle", {29'd0, result[18:16]}, 32'd1);
        for (int i = 0; i <= SERVE_FRAMES; i++) run(1'b0, 32'h0, 1'b1, 1'b0, 0, 0);
        run(1'b0, 32'h0, 1'b0, 1'b1, 314, 238);
        check("serve_left_314", rgb(), 32'd5);
        run(1'b0, 32'h0, 1'b0, 1'b1, 322, 238);
        check("serve_left_322", rgb(), 32'd1);

        // Player 1 wins: paddle2 kept clear, paddle1 tracking.
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            if (m_state == 4) found = 1;
            else run(1'b1, (i % 2) ? cmd(1, away(m_by)) : cmd(0, track(m_by)), 1'b1, 1'b1, m_bx + 1, m_by + 1);
        end
        if (!found) check("game_timeout", 32'd1, 32'd0);
        check("over_state", result, 32'h0004_0107);
        run(1'b0, 32'h0, 1'b1, 1'b1, m_bx + 2, m_by + 2);
        check("over_ball_hidden", rgb(), 32'd1);
        check("over_hold", result, 32'h0004_0107);
        run(1'b1, 32'h4000_0000, 1'b0, 1'b1, 0, 0);
        check("restart", result, 32'h0001_0000);

        // Reset during PLAY: block must idle afterwards until START.
        for (int i = 0; i < SERVE_FRAMES + 20; i++) run(1'b0, 32'h0, 1'b1, 1'b1, m_bx, m_by);
        check("pre_reset_play", {29'd0, result[18:16]}, 32'd2);
        RST_BTN = 1'b0;
        #1;
        model_reset();
        check("midplay_reset_result", result, 32'h0);
        check("midplay_reset_rgb", rgb(), 32'h0);
        @(posedge CLK);
        #1 RST_BTN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = int'($urandom_range(0, 3));
            d = (r == 2) ? cmd(3, 0) : cmd(r % 2, int'($urandom_range(0, 1023)));
            pp = pick_pix();
            run(1'b1, d, 1'b1, 1'b1, int'(pp[19:10]), int'(pp[9:0]));
        end
        check("idle_after_reset", {29'd0, result[18:16]}, 32'd0);

        // Random play against the model.
        run(1'b1, 32'h4000_0000, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 5000; i++) begin
            en  = ($urandom_range(0, 3) == 0);
            tk  = ($urandom_range(0, 7) != 0);
            act = ($urandom_range(0, 7) != 0);
            r   = int'($urandom_range(0, 127));
            if (r < 112)
                d = cmd(r < 56 ? 0 : 1, ($urandom_range(0, 1) != 0) ? track(m_by) : int'($urandom_range(0, 1023)));
            else if (r < 118)
                d = cmd(2, 0);
            else if (r < 119)
                d = cmd(3, 0);
            else
                d = cmd(int'($urandom_range(4, 7)), 0);
            d = d | ($urandom & 32'h1FFF_FC00) | (r >= 119 ? ($urandom & 32'h3FF) : 32'h0);
            pp = pick_pix();
            run(en, d, tk, act, int'(pp[19:10]), int'(pp[9:0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_arena.md
PONG_ARENA -- requirements
Module: pong_arena

Interface
REQ-001 Parameter H_RES, default 640: active width in pixels.
REQ-002 Parameter V_RES, default 480: active height in pixels.
REQ-003 Parameter PAD_W, default 8; PAD_H, default 60: paddle size.
REQ-004 Parameter PAD1_X, default 20; PAD2_X, default 620: paddle left-edge x.
REQ-005 Parameter BALL_SZ, default 8; BALL_SPD, default 2: ball side and pixels moved per frame per axis.
REQ-006 Parameter WIN_SCORE, default 7; SERVE_FRAMES, default 60.
REQ-007 Parameter FG_RGB, default 3'b101; BG_RGB, default 3'b001.
REQ-008 CLK  in  1  single clock; all state on rising edge.
REQ-009 RST_BTN  in  1  asynchronous, active-low reset.
REQ-010 CLK_EN  in  1  one-cycle custom-instruction command strobe.
REQ-011 dataa  in  32  command word: [31:29] opcode, [9:0] argument.
REQ-012 result  out  32  status: [7:0] score1, [15:8] score2, [18:16] state code, rest 0.
REQ-013 FRAME_TICK  in  1  one-cycle pulse per frame (end of vertical active).
REQ-014 ACTIVE  in  1  current pixel in active area.
REQ-015 PIX_X, PIX_Y  in  10 each  current pixel coordinates.
REQ-016 VGA_R, VGA_G, VGA_B  out  1 each  registered pixel colour.

Function
REQ-017 States, with codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-018 Opcodes, acted on only in a cycle with CLK_EN=1: 0 = set paddle1 y, 1 = set paddle2 y, 2 = START, 3 = clear scores; any other opcode is ignored.
REQ-019 Paddle y is the top edge; a written value is clamped to [0, V_RES-PAD_H] and registered one cycle after the strobe.
REQ-020 START is accepted only in IDLE or OVER: it clears both scores, sets serve direction to right, and moves to SERVE.
REQ-021 Clear-scores is accepted in any state; it does not change the state.
REQ-022 SERVE: ball = (H_RES/2-BALL_SZ/2, V_RES/2-BALL_SZ/2), dy = down; a frame counter counts FRAME_TICKs; state -> PLAY on the SERVE_FRAMES-th tick.
REQ-023 PLAY: the ball updates only on FRAME_TICK; nx = x±BALL_SPD, ny = y±BALL_SPD.
REQ-024 Wall, top: if ny <= 0 -> y = 0 and dy = down.
REQ-025 Wall, bottom: if ny >= V_RES-BALL_SZ -> y = V_RES-BALL_SZ and dy = up.
REQ-026 Left paddle hit, all of:
- moving left;
- nx <= PAD1_X+PAD_W;
- x > PAD1_X+PAD_W-BALL_SPD-1;
- ball rows overlap [pad1_y, pad1_y+PAD_H-1].
Response: x = PAD1_X+PAD_W, dx = right.
REQ-027 Right paddle hit: mirror of REQ-026 against PAD2_X; response x = PAD2_X-BALL_SZ, dx = left.
REQ-028 Miss: nx <= 0 (left) -> score2+1, serve direction left; nx >= H_RES-BALL_SZ (right) -> score1+1, serve direction right; state -> POINT.
REQ-029 Priority: paddle hit over miss; wall and paddle responses may apply in the same tick.
REQ-030 POINT lasts exactly one cycle: if either score equals WIN_SCORE -> OVER, else -> SERVE.
REQ-031 OVER holds the ball position and scores until START.
REQ-032 Scores saturate at 255; arithmetic is unsigned; signed direction is held as a separate flag per axis.
REQ-033 Simultaneous CLK_EN and FRAME_TICK: both are processed; collision uses the pre-write paddle y.
REQ-034 Pixel colour is registered, one-cycle latency:
- !ACTIVE -> 000;
- pixel inside either paddle, or inside the ball (ball drawn only in SERVE/PLAY/POINT) -> FG_RGB;
- else BG_RGB.
REQ-035 result is combinational from registers; it is valid in the same cycle as CLK_EN.

Reset
REQ-036 RST_BTN low, asynchronously:
- state = IDLE; scores = 0;
- paddles = (V_RES-PAD_H)/2;
- ball centred, dx = right, dy = down;
- frame counter = 0;
- VGA_R/G/B = 0.
REQ-037 Reset mid-PLAY discards the point in progress; after release the block idles until START.

Verification
REQ-038 Reset, then CLK_EN with dataa=0x0000_0300 (paddle1 y=768) -> paddle1 y = 420 next cycle; result = 0x0000_0000.
REQ-039 START, then 60 FRAME_TICKs -> result[18:16] = 2; ball at (316,236) until the first PLAY tick, then (318,238).
REQ-040 PLAY with ball x=30 moving left, paddle1 y overlapping the ball -> next tick x = 28, dx = right, no score change.
REQ-041 Paddle moved away, ball x=2 moving left -> score2 = 1; POINT for one cycle; then SERVE with dx = left.
REQ-042 score1=6, right miss -> score1 = 7; state OVER (code 4); ball not drawn; a later START -> scores 0, state SERVE.
REQ-043 Pixel check: ACTIVE=1 at (22,250) with paddle1 y=240 -> RGB = 101 one cycle later; ACTIVE=0 -> 000.
